// File: rtl/apple1_inject_pkg.sv
// rtl/apple1_inject_pkg.sv - shared types, ASCII constants and byte translation for the text injector
//
// Purpose: FSM state encoding, the ASCII / Apple-I constants, and the pure
// byte-to-keyboard-code translation used by apple1_text_injector.
// Ports: none (package).

package apple1_inject_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        XLATE,
        PRESENT,
        GAP
    } state_t;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] A1_CR  = 8'h8D;

    // Returns {drop, code}. CR and LF both map to the Apple-I CR here; the
    // CRLF collapse needs history, so the caller decides whether an LF drops.
    function automatic logic [8:0] a1_xlate(input logic [7:0] b, input logic upcase);
        logic [7:0] c;
        logic       drop;
        c    = 8'h00;
        drop = 1'b1;
        if (b == ASC_CR || b == ASC_LF) begin
            c    = A1_CR;
            drop = 1'b0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            c = b;
            if (upcase && b >= 8'h61 && b <= 8'h7A) begin
                c = b & 8'hDF;
            end
            c    = c | 8'h80;
            drop = 1'b0;
        end
        return {drop, c};
    endfunction

endpackage

// File: rtl/apple1_sync_fifo.sv
// rtl/apple1_sync_fifo.sv - single-clock FIFO with registered read data and synchronous flush
//
// Purpose: byte buffer between the download port and the injector FSM.
// Read data appears on rdata in the cycle after pop is accepted.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous clear of pointers and count (wins over push/pop)
//   push, wdata     write strobe and data (ignored when full unless popping)
//   pop, rdata      read strobe (ignored when empty) and registered read data
//   count           current fill level, 0..DEPTH
//   full, empty     fill-level flags

module apple1_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~flush;
    // A pop in the same cycle frees a slot, so a push into a full FIFO fits.
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap at DEPTH naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apple1_text_injector.sv
// rtl/apple1_text_injector.sv - streams downloaded text into the Apple-I keyboard port with pacing
//
// Purpose: buffers bytes from the HPS download port, translates them to
// Apple-I keyboard codes and presents them one at a time to the PIA with a
// valid/ack handshake, inserting idle gaps after each character.
// Ports:
//   clk_sys, reset                  clock, asynchronous active-high reset
//   ioctl_download/wr/index/dout    HPS download port (byte strobe interface)
//   ioctl_wait                      registered back-pressure to hps_io
//   key_valid, key_data, key_ack    keyboard code handshake to the PIA
//   busy                            download or injection in progress
//   overflow                        sticky: a byte was dropped on a full FIFO

module apple1_text_injector
    import apple1_inject_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         CHAR_DELAY = 2500,
    parameter int         CR_DELAY   = 250000,
    parameter logic [7:0] INDEX      = 8'd1,
    parameter bit         UPCASE     = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ioctl_download,
    input  logic       ioctl_wr,
    input  logic [7:0] ioctl_index,
    input  logic [7:0] ioctl_dout,
    output logic       ioctl_wait,
    output logic       key_valid,
    output logic [7:0] key_data,
    input  logic       key_ack,
    output logic       busy,
    output logic       overflow
);

    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int MAX_DELAY = (CHAR_DELAY > CR_DELAY) ? CHAR_DELAY : CR_DELAY;
    localparam int GW        = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;

    localparam logic [CW-1:0] WAIT_TH = CW'(FIFO_DEPTH - 1);
    localparam logic [GW-1:0] CHAR_LD = GW'(CHAR_DELAY);
    localparam logic [GW-1:0] CR_LD   = GW'(CR_DELAY);

    state_t          state;
    state_t          next_state;
    logic            dl_q;
    logic            dl_match;
    logic            start;
    logic            accept;
    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [8:0]      xl;
    logic            xlate_drop;
    logic            prev_was_cr;
    logic [GW-1:0]   gap_cnt;

    assign dl_match = ioctl_download & (ioctl_index == INDEX);
    // Only a new download aimed at this block restarts it; the falling edge
    // is deliberately ignored so the buffered text keeps draining.
    assign start    = dl_match & ~dl_q;
    assign accept   = dl_match & ioctl_wr;
    assign fifo_push = accept & (~fifo_full | fifo_pop);

    apple1_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .flush (start),
        .push  (fifo_push),
        .wdata (ioctl_dout),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // fifo_rdata stays stable through XLATE because it only moves on a pop.
    assign xl         = a1_xlate(fifo_rdata, UPCASE);
    assign xlate_drop = xl[8] | ((fifo_rdata == ASC_LF) & prev_was_cr);

    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = POP;
                end
            end
            POP:     next_state = XLATE;
            XLATE:   next_state = xlate_drop ? IDLE : PRESENT;
            PRESENT: begin
                if (key_ack) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dl_q        <= 1'b0;
            key_data    <= 8'h00;
            prev_was_cr <= 1'b0;
            gap_cnt     <= '0;
            overflow    <= 1'b0;
            ioctl_wait  <= 1'b0;
        end else begin
            dl_q       <= dl_match;
            ioctl_wait <= (fifo_count >= WAIT_TH);
            if (start) begin
                state       <= IDLE;
                prev_was_cr <= 1'b0;
                gap_cnt     <= '0;
                overflow    <= 1'b0;
            end else begin
                state <= next_state;
                if (state == XLATE) begin
                    prev_was_cr <= (fifo_rdata == ASC_CR);
                    if (!xlate_drop) begin
                        key_data <= xl[7:0];
                    end
                end
                if (state == PRESENT && key_ack) begin
                    gap_cnt <= (key_data == A1_CR) ? CR_LD : CHAR_LD;
                end else if (state == GAP && gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                if (accept && fifo_full && !fifo_pop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // key_valid follows the state register, so an asynchronous reset drops
    // it immediately and an ack while not presenting has nothing to clear.
    assign key_valid = (state == PRESENT);
    assign busy      = dl_match | ~fifo_empty | (state != IDLE);

endmodule

// File: tb/tb_apple1_text_injector.sv
// tb/tb_apple1_text_injector.sv - self-checking bench for apple1_text_injector

module tb_apple1_text_injector;

    localparam int DEPTH  = 4;
    localparam int CHAR_D = 5;
    localparam int CR_D   = 20;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_index;
    logic [7:0] ioctl_dout;
    logic       key_ack;

    logic       ioctl_wait, key_valid, busy, overflow;
    logic [7:0] key_data;
    logic       ioctl_wait_lc, key_valid_lc, busy_lc, overflow_lc;
    logic [7:0] key_data_lc;

    always #5 clk_sys = ~clk_sys;

    apple1_text_injector #(
        .FIFO_DEPTH (DEPTH),
        .CHAR_DELAY (CHAR_D),
        .CR_DELAY   (CR_D),
        .INDEX      (8'd1),
        .UPCASE     (1'b1)
    ) u_dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .key_valid      (key_valid),
        .key_data       (key_data),
        .key_ack        (key_ack),
        .busy           (busy),
        .overflow       (overflow)
    );

    apple1_text_injector #(
        .FIFO_DEPTH (DEPTH),
        .CHAR_DELAY (CHAR_D),
        .CR_DELAY   (CR_D),
        .INDEX      (8'd1),
        .UPCASE     (1'b0)
    ) u_dut_lc (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait_lc),
        .key_valid      (key_valid_lc),
        .key_data       (key_data_lc),
        .key_ack        (key_ack),
        .busy           (busy_lc),
        .overflow       (overflow_lc)
    );

    typedef struct {
        logic [7:0] code;
        logic [7:0] code_lc;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic m_prev_cr;
    int   m_has_prev;
    int   m_last_delay;
    int   m_drops;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [8:0] model_code(input logic [7:0] b, input logic prev_cr, input bit up);
        logic [7:0] c;
        if (b == 8'h0D) return {1'b0, 8'h8D};
        if (b == 8'h0A) return prev_cr ? 9'h100 : {1'b0, 8'h8D};
        if (b < 8'h20 || b > 8'h7E) return 9'h100;
        c = b;
        if (up && c >= 8'h61 && c <= 8'h7A) c = c - 8'd32;
        return {1'b0, 8'h80 + c};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_prev_cr  = 1'b0;
        m_has_prev = 0;
        m_drops    = 0;
    endtask

    // Expected gap = ack-to-valid edges: GAP (delay+1) + IDLE/POP/XLATE,
    // plus three cycles for every dropped byte in between.
    task automatic model_push(input logic [7:0] b);
        logic [8:0] r_up, r_lc;
        exp_t e;
        r_up = model_code(b, m_prev_cr, 1'b1);
        r_lc = model_code(b, m_prev_cr, 1'b0);
        if (r_up[8]) begin
            m_drops++;
        end else begin
            e.code    = r_up[7:0];
            e.code_lc = r_lc[7:0];
            e.gap     = (m_has_prev != 0) ? (m_last_delay + 4 + 3 * m_drops) : -1;
            sb.push_back(e);
            m_has_prev   = 1;
            m_last_delay = (r_up[7:0] == 8'h8D) ? CR_D : CHAR_D;
            m_drops      = 0;
        end
        m_prev_cr = (b == 8'h0D);
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        tick();
        model_reset();
    endtask

    task automatic write_byte(input logic [7:0] b);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        tick();
        ioctl_wr   = 1'b0;
        model_push(b);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (key_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: key_valid=%b required 1 within 40 cycles", name, key_valid);
        end
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   g;
        bit   got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            g   = 0;
            got = 0;
            while (!got && g < CR_D + 60) begin
                if (key_valid === 1'b1) got = 1;
                else begin
                    tick();
                    g++;
                end
            end
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL %s_timeout: key_valid=%b required 1 (code %h)", name, key_valid, e.code);
                sb.delete();
                return;
            end
            checks++;
            if (key_data !== e.code) begin
                errors++;
                $display("FAIL %s_code: key_data=%h required %h", name, key_data, e.code);
            end
            checks++;
            if (key_valid_lc !== 1'b1 || key_data_lc !== e.code_lc) begin
                errors++;
                $display("FAIL %s_code_lc: valid=%b key_data=%h required 1/%h", name, key_valid_lc, key_data_lc, e.code_lc);
            end
            if (e.gap >= 0) begin
                checks++;
                if (g !== e.gap) begin
                    errors++;
                    $display("FAIL %s_gap: cycles=%0d required %0d (code %h)", name, g, e.gap, e.code);
                end
            end
            key_ack = 1'b1;
            tick();
            key_ack = 1'b0;
        end
        m_has_prev = 0;
        m_drops    = 0;
        got = 0;
        for (int i = 0; i < CR_D + 20; i++) begin
            if (key_valid === 1'b1 || key_valid_lc === 1'b1) got = 1;
            tick();
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL %s_stray: key_valid seen=%b required 0", name, got);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({ioctl_wait, key_valid, busy, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: wait/valid/busy/ovf=%b required 0000", {ioctl_wait, key_valid, busy, overflow});
        end
        checks++;
        if (key_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_key_data: key_data=%h required 00", key_data);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({ioctl_wait, key_valid, busy, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: wait/valid/busy/ovf=%b required 0000", {ioctl_wait, key_valid, busy, overflow});
        end
    endtask

    task automatic test_latency();
        start_download(8'd1);
        write_byte(8'h4B);
        tick();
        tick();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: key_valid=%b required 0 at N+3", key_valid);
        end
        tick();
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: key_valid=%b required 1 at N+4", key_valid);
        end
        drain("latency");
    endtask

    task automatic test_hi_crlf();
        logic [7:0] msg [5];
        msg = '{8'h48, 8'h49, 8'h0D, 8'h0A, 8'h41};
        start_download(8'd1);
        foreach (msg[i]) write_byte(msg[i]);
        drain("hi_crlf");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL hi_overflow: overflow=%b required 0", overflow);
        end
    endtask

    task automatic test_upcase_drop();
        logic [7:0] msg [5];
        msg = '{8'h61, 8'h09, 8'h80, 8'h7A, 8'h0A};
        start_download(8'd1);
        foreach (msg[i]) write_byte(msg[i]);
        drain("upcase_drop");
    endtask

    task automatic test_overflow();
        int wait_first, ovf_first;
        wait_first = -1;
        ovf_first  = -1;
        start_download(8'd1);
        for (int k = 0; k < 8; k++) begin
            ioctl_wr   = 1'b1;
            ioctl_dout = 8'h41 + 8'(k);
            tick();
            if (k < 5) model_push(8'h41 + 8'(k));
            if (ioctl_wait === 1'b1 && wait_first < 0) wait_first = k;
            if (overflow === 1'b1 && ovf_first < 0) ovf_first = k;
        end
        ioctl_wr = 1'b0;
        checks++;
        if (wait_first !== 4) begin
            errors++;
            $display("FAIL ovf_wait_rise: first at write %0d required 4", wait_first);
        end
        checks++;
        if (ovf_first !== 5) begin
            errors++;
            $display("FAIL ovf_set: first at write %0d required 5", ovf_first);
        end
        drain("overflow");
        checks++;
        if (overflow !== 1'b1 || ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: overflow=%b wait=%b required 1/0", overflow, ioctl_wait);
        end
        start_download(8'd1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flush_clear: overflow=%b required 0", overflow);
        end
    endtask

    task automatic test_restart();
        start_download(8'd1);
        write_byte(8'h41);
        write_byte(8'h42);
        write_byte(8'h43);
        wait_valid("restart_present");
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        model_reset();
        checks++;
        if (key_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_flush: key_valid=%b busy=%b required 0/1", key_valid, busy);
        end
        write_byte(8'h5A);
        tick();
        tick();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_early: key_valid=%b required 0 at N+3", key_valid);
        end
        tick();
        checks++;
        if (key_valid !== 1'b1 || key_data !== 8'hDA) begin
            errors++;
            $display("FAIL restart_first: key_valid=%b key_data=%h required 1/da", key_valid, key_data);
        end
        drain("restart");
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_index0();
        bit bad;
        bad = 0;
        ioctl_download = 1'b0;
        tick();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        ioctl_wr   = 1'b1;
        ioctl_dout = 8'h41;
        tick();
        ioctl_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy !== 1'b0 || key_valid !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL index0: busy/key_valid went high=%b required 0", bad);
        end
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_reset_present();
        bit bad;
        bad = 0;
        start_download(8'd1);
        write_byte(8'h51);
        write_byte(8'h52);
        write_byte(8'h53);
        wait_valid("rst_present_valid");
        ioctl_download = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || key_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_async: valid=%b busy=%b data=%h required 0/0/00", key_valid, busy, key_data);
        end
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || key_valid !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_release_idle: busy/key_valid went high=%b required 0", bad);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_dout     = 8'h00;
        key_ack        = 1'b0;
        model_reset();
        test_reset();
        test_latency();
        test_hi_crlf();
        test_upcase_drop();
        test_overflow();
        test_restart();
        test_index0();
        test_reset_present();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
